// File: rtl/riscv_shift_pkg.sv
// Shared types and constants for the RV64 sequential right shifter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_shift_pkg;

    // Default datapath width; 32 is the only other legal value.
    localparam int XLEN_DEFAULT = 64;

    // Width of the W-variant (SRLW/SRAW) operand.
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_right_stage.sv
// One barrel stage: shifts right by 2^K with a fill bit when enabled, else passthrough.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   operand : value entering the stage
//   enable  : apply this stage's shift distance
//   fill    : bit written into the vacated top positions
//   result  : stage output
module shift_right_stage #(
    parameter int XLEN = 64,
    parameter int K    = 0
) (
    input  logic [XLEN-1:0] operand,
    input  logic            enable,
    input  logic            fill,
    output logic [XLEN-1:0] result
);

    localparam int DIST = 1 << K;

    // Ones in exactly the top DIST bit positions.
    localparam logic [XLEN-1:0] FILL_MASK = ~({XLEN{1'b1}} >> DIST);

    logic [XLEN-1:0] shifted;

    assign shifted = (operand >> DIST) | (fill ? FILL_MASK : '0);
    assign result  = enable ? shifted : operand;

endmodule

// File: rtl/shift_right_seq.sv
// Multi-cycle SRL/SRA/SRLW/SRAW, resolving one shift-amount bit per cycle.
// Latency: fixed; out_valid rises SHW+1 cycles after the accept cycle (7 for XLEN=64).
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
//
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   in_valid/in_ready      : request handshake (in_data, in_shamt, in_arith, in_word)
//   flush                  : synchronous abort of any in-flight operation
//   out_valid/out_ready    : result handshake (out_data)
//   busy                   : block is not IDLE
module shift_right_seq
    import riscv_shift_pkg::*;
#(
    parameter  int XLEN = XLEN_DEFAULT,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_data,
    input  logic [SHW-1:0]  in_shamt,
    input  logic            in_arith,
    input  logic            in_word,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            busy
);

    localparam int KW = $clog2(SHW);
    localparam logic [KW-1:0]   K_LAST        = KW'(SHW - 1);
    // W-variants only use the low five amount bits.
    localparam logic [SHW-1:0]  WORD_AMT_MASK = SHW'(WORD_W - 1);
    localparam logic [XLEN-1:0] LO_MASK       = {XLEN{1'b1}} >> (XLEN - WORD_W);

    // Sign-extend the low WORD_W bits to XLEN via a left/arithmetic-right pair,
    // which degenerates cleanly to identity when XLEN == WORD_W.
    function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
        logic signed [XLEN-1:0] t;
        t = v << (XLEN - WORD_W);
        return t >>> (XLEN - WORD_W);
    endfunction

    state_e          state_q, state_d;
    logic [XLEN-1:0] operand_q;
    logic [SHW-1:0]  amt_q;
    logic            fill_q;
    logic            word_q;
    logic [KW-1:0]   k_q;

    logic            accept;
    logic [XLEN-1:0] prep_op;
    logic [SHW-1:0]  prep_amt;
    logic            prep_fill;
    logic [XLEN-1:0] stage_out [SHW];
    logic [XLEN-1:0] stage_sel;

    // ------------------------------------------------------------------
    // Operand preparation at accept
    // ------------------------------------------------------------------
    always_comb begin
        prep_op = in_data;
        if (in_word) begin
            prep_op = in_arith ? sext_word(in_data) : (in_data & LO_MASK);
        end
    end

    assign prep_amt  = in_word ? (in_shamt & WORD_AMT_MASK) : in_shamt;
    assign prep_fill = in_arith & prep_op[XLEN-1];

    // flush beats accept
    assign accept = (state_q == IDLE) && in_valid && !flush;

    // ------------------------------------------------------------------
    // Barrel stages; each one is enabled by its own amount bit and the
    // counter picks which stage result is written back this cycle.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < SHW; g++) begin : g_stage
        shift_right_stage #(
            .XLEN (XLEN),
            .K    (g)
        ) u_stage (
            .operand (operand_q),
            .enable  (amt_q[g]),
            .fill    (fill_q),
            .result  (stage_out[g])
        );
    end

    always_comb begin
        stage_sel = operand_q;
        for (int i = 0; i < SHW; i++) begin
            if (k_q == KW'(i)) begin
                stage_sel = stage_out[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (in_valid)       state_d = SHIFT;
                SHIFT:   if (k_q == K_LAST)  state_d = DONE;
                DONE:    if (out_ready)      state_d = IDLE;
                default:                     state_d = IDLE;
            endcase
        end
    end

    // FSM: outputs (decoded from the state register only)
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            operand_q <= '0;
            amt_q     <= '0;
            fill_q    <= 1'b0;
            word_q    <= 1'b0;
            k_q       <= '0;
        end else if (accept) begin
            operand_q <= prep_op;
            amt_q     <= prep_amt;
            fill_q    <= prep_fill;
            word_q    <= in_word;
            k_q       <= '0;
        end else if (state_q == SHIFT && !flush) begin
            operand_q <= stage_sel;
            k_q       <= k_q + 1'b1;
        end
    end

    // Word results are re-sign-extended from bit 31 of the registered operand.
    assign out_data = word_q ? sext_word(operand_q) : operand_q;

endmodule

// File: tb/tb_shift_right_seq.sv
module tb_shift_right_seq;

    localparam int XLEN = 64;
    localparam int SHW  = 6;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_data;
    logic [SHW-1:0]  in_shamt;
    logic            in_arith;
    logic            in_word;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic            busy;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q [$];

    shift_right_seq #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_arith  (in_arith),
        .in_word   (in_word),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, act, exp);
        end
    endtask

    // Reference behaviour written directly with the language shift operators.
    function automatic logic [63:0] model(input logic [63:0] d, input logic [5:0] s,
                                          input logic a, input logic w);
        logic [31:0] r32;
        logic [63:0] r;
        if (w) begin
            if (a) r32 = $signed(d[31:0]) >>> s[4:0];
            else   r32 = d[31:0] >> s[4:0];
            r = {{32{r32[31]}}, r32};
        end else begin
            if (a) r = $signed(d) >>> s;
            else   r = d >> s;
        end
        return r;
    endfunction

    // Presents one request; the accept happens on the posedge inside.
    task automatic issue(input logic [63:0] d, input logic [5:0] s, input logic a, input logic w);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_arith = a;
        in_word  = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Waits for the result, checks latency and value against the scoreboard, then handshakes.
    task automatic collect(input string tag);
        int  lat;
        bit  seen;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check_val({tag, "_timeout"}, 64'd0, 64'd1);
            void'(exp_q.pop_front());
        end else begin
            check_val({tag, "_lat"}, 64'(lat), 64'd7);
            if (exp_q.size() == 0) check_val({tag, "_sb_empty"}, 64'd0, 64'd1);
            else                   check_val(tag, out_data, exp_q.pop_front());
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] d, input logic [5:0] s,
                          input logic a, input logic w, input logic [63:0] exp);
        exp_q.push_back(exp);
        issue(d, s, a, w);
        collect(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] d, hold_dat, bp_exp;
        logic [5:0]  s;
        logic        a, w;
        int          seen_cnt;
        bit          got;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_arith  = 1'b0;
        in_word   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;

        #12;
        check_val("rst_in_ready",  64'(in_ready),  64'd1);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_out_data",  out_data,       64'd0);
        check_val("rst_busy",      64'(busy),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-derived results
        run_op("srl_max",   64'h8000_0000_0000_0000, 6'd63, 1'b0, 1'b0, 64'h0000_0000_0000_0001);
        run_op("sra_4",     64'h8000_0000_0000_0000, 6'd4,  1'b1, 1'b0, 64'hF800_0000_0000_0000);
        run_op("sra_pos63", 64'h7FFF_FFFF_FFFF_FFFF, 6'd63, 1'b1, 1'b0, 64'h0);
        run_op("sra_neg63", 64'h8000_0000_0000_0001, 6'd63, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("sraw_31",   64'h1234_5678_8000_0000, 6'd31, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("srlw_0",    64'h0000_0000_8000_0001, 6'd0,  1'b0, 1'b1, 64'hFFFF_FFFF_8000_0001);
        run_op("srlw_33",   64'hABCD_0000_8000_0004, 6'd33, 1'b0, 1'b1, 64'h0000_0000_4000_0002);
        run_op("srlw_31",   64'h0000_0000_8000_0000, 6'd31, 1'b0, 1'b1, 64'h0000_0000_0000_0001);
        run_op("sraw_pos",  64'hFFFF_FFFF_7000_0000, 6'd4,  1'b1, 1'b1, 64'h0000_0000_0700_0000);

        // Random mix checked against the operator model
        for (int i = 0; i < 16; i++) begin
            d = {$urandom, $urandom};
            s = 6'($urandom_range(0, 63));
            a = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            run_op("rand", d, s, a, w, model(d, s, a, w));
        end

        // Backpressure in DONE
        bp_exp = model(64'hF0F0_0000_1234_5678, 6'd12, 1'b1, 1'b0);
        issue(64'hF0F0_0000_1234_5678, 6'd12, 1'b1, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check_val("bp_valid_seen", 64'(got), 64'd1);
        hold_dat = out_data;
        for (int i = 0; i < 5; i++) begin
            check_val("bp_out_valid", 64'(out_valid), 64'd1);
            check_val("bp_out_data",  out_data,       bp_exp);
            check_val("bp_stable",    out_data,       hold_dat);
            check_val("bp_in_ready",  64'(in_ready),  64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_val("bp_rel_in_ready",  64'(in_ready),  64'd1);
        check_val("bp_rel_out_valid", 64'(out_valid), 64'd0);

        // Flush in the third SHIFT cycle
        issue(64'hDEAD_BEEF_CAFE_F00D, 6'd5, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        seen_cnt = 0;
        @(negedge clk);
        check_val("flush_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen_cnt++;
            @(negedge clk);
        end
        check_val("flush_no_valid", 64'(seen_cnt), 64'd0);
        run_op("post_flush", 64'h0000_0000_0000_0F00, 6'd8, 1'b0, 1'b0, 64'h0000_0000_0000_000F);

        // Asynchronous reset mid-SHIFT
        issue(64'h8765_4321_0FED_CBA9, 6'd1, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("arst_in_ready",  64'(in_ready),  64'd1);
        check_val("arst_out_valid", 64'(out_valid), 64'd0);
        check_val("arst_out_data",  out_data,       64'd0);
        check_val("arst_busy",      64'(busy),      64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_srl", 64'h0000_0000_0000_00FF, 6'd4, 1'b0, 1'b0, 64'h0000_0000_0000_000F);

        check_val("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
